// File: rtl/coef_stream_slicer.sv
// coef_stream_slicer
//   Buffers one packed polynomial word of NUM_COEF coefficients and streams it
//   out LANES coefficients per beat. The order is natural or bit-reversed,
//   selected per word by in_bitrev. The input is accepted on the last output
//   beat, so consecutive words stream with no bubble.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   in_valid/ready  input handshake; in_data holds NUM_COEF packed coefficients,
//                   in_bitrev is the order mode captured with the word
//   out_valid/ready output handshake; out_data holds LANES coefficients,
//                   out_idx is the sequence position of lane 0,
//                   out_last flags the final beat of the word
//   busy            a word is still draining (same as out_valid)

// Lane mux: picks one coefficient for sequence position base_idx+LANE.
module coef_stream_lane #(
  parameter int COEF_W   = 8,
  parameter int NUM_COEF = 8,
  parameter int IDX_W    = 3,
  parameter int LANE     = 0
) (
  input  logic [NUM_COEF*COEF_W-1:0] buf_data,
  input  logic [IDX_W-1:0]           base_idx,
  input  logic                       mode,
  output logic [COEF_W-1:0]          coef
);
  logic [IDX_W-1:0] pos, rpos, sel;

  always_comb begin
    // base_idx is a multiple of LANES, so OR-ing in the lane number is an add
    pos  = base_idx | IDX_W'(LANE);
    rpos = '0;
    for (int b = 0; b < IDX_W; b++) rpos[b] = pos[IDX_W-1-b];
    sel  = mode ? rpos : pos;
  end

  assign coef = buf_data[sel*COEF_W +: COEF_W];
endmodule

module coef_stream_slicer #(
  parameter int COEF_W   = 8,
  parameter int NUM_COEF = 8,
  parameter int LANES    = 2,
  localparam int IDX_W   = (NUM_COEF > 2) ? $clog2(NUM_COEF) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NUM_COEF*COEF_W-1:0] in_data,
  input  logic                       in_bitrev,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES*COEF_W-1:0]    out_data,
  output logic [IDX_W-1:0]           out_idx,
  output logic                       out_last,
  output logic                       busy
);
  localparam int BEATS = NUM_COEF / LANES;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LOG_L = $clog2(LANES);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t                     state;
  logic [NUM_COEF*COEF_W-1:0] buf_data;
  logic                       mode;
  logic [CNT_W-1:0]           cnt;
  logic [IDX_W-1:0]           base_idx;
  logic                       accept, xfer, at_last;

  assign at_last   = (cnt == CNT_W'(BEATS-1));
  assign out_valid = (state == FULL);
  assign busy      = out_valid;
  assign out_last  = out_valid & at_last;
  assign base_idx  = IDX_W'(cnt) << LOG_L;
  assign out_idx   = base_idx;

  // Refill only when idle or when the last beat leaves this cycle. Held low
  // during reset so no word can slip in on the reset edge.
  assign in_ready = ~rst & ((state == EMPTY) | (out_last & out_ready));
  assign accept   = in_valid & in_ready;
  assign xfer     = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= EMPTY;
      buf_data <= '0;
      mode     <= 1'b0;
      cnt      <= '0;
    end else if (accept) begin
      state    <= FULL;
      buf_data <= in_data;
      mode     <= in_bitrev;
      cnt      <= '0;
    end else if (xfer) begin
      // counter holds on the final beat so out_data keeps the last beat
      if (at_last) state <= EMPTY;
      else         cnt   <= cnt + 1'b1;
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    coef_stream_lane #(
      .COEF_W(COEF_W), .NUM_COEF(NUM_COEF), .IDX_W(IDX_W), .LANE(l)
    ) u_lane (
      .buf_data(buf_data),
      .base_idx(base_idx),
      .mode    (mode),
      .coef    (out_data[l*COEF_W +: COEF_W])
    );
  end
endmodule

// File: doc/coef_stream_slicer.md
Name: coef_stream_slicer

Overview:
- Parametrised, sequential successor to the combinational 64-bit byte slicer in the NTT datapath.
- Accepts one packed polynomial word of NUM_COEF coefficients over a valid/ready handshake and buffers it.
- Streams the coefficients out LANES per beat, in natural or bit-reversed order, to the butterfly/NTT stage.
- Supports back-to-back words with no bubble and full output backpressure.

Parameters:
COEF_W, 8, bits per coefficient
NUM_COEF, 8, coefficients per input word; power of 2, >= 2
LANES, 2, coefficients emitted per output beat; power of 2, divides NUM_COEF
(derived) BEATS = NUM_COEF/LANES; IDX_W = log2(NUM_COEF), minimum 1

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  input word valid
in_ready  out  1  block can accept a word this cycle
in_data  in  NUM_COEF*COEF_W  packed word; coefficient i = in_data[i*COEF_W +: COEF_W]
in_bitrev  in  1  order mode, captured with in_data: 0 = natural, 1 = bit-reversed
out_valid  out  1  out_data holds a valid beat
out_ready  in  1  downstream accepts the beat
out_data  out  LANES*COEF_W  lane l = out_data[l*COEF_W +: COEF_W]
out_idx  out  IDX_W  sequence position of lane 0 = beat*LANES
out_last  out  1  final beat of the current word
busy  out  1  buffer holds an undrained word (equals out_valid)

Behaviour:
- One clock domain; all state updates on rising clk. rst is synchronous and active-high.
- While rst is high: buffer = 0, beat counter = 0, mode = 0, out_valid = 0, out_data = 0, out_idx = 0, out_last = 0, busy = 0, in_ready = 0.
- After rst is released, in_ready = 1.
- Two states:
  - EMPTY: in_ready = 1.
  - FULL: in_ready = out_valid & out_ready & out_last.
- in_ready is combinational from state, counter and out_ready. It never depends on in_valid.
- Input accept = in_valid & in_ready. On accept:
  - buffer <= in_data, mode <= in_bitrev, counter <= 0, state <= FULL.
- Latency: a word accepted at edge t presents beat 0 at cycle t+1.
- Beat k output mapping:
  - Position p = k*LANES + l.
  - Natural mode: lane l = coefficient p.
  - Bit-reversed mode: lane l = coefficient rev(p), where rev reverses the IDX_W bits of p.
- out_data, out_idx and out_last are driven from registered state only (buffer, counter, mode). No combinational path from in_* to out_*.
- out_last = 1 when counter = BEATS-1.
- Beat transfer = out_valid & out_ready.
  - Not the last beat: counter increments.
  - Last beat, no simultaneous accept: state <= EMPTY and out_valid drops next cycle. out_data retains the buffer contents.
  - Last beat with a simultaneous accept: new word loaded, counter <= 0, out_valid stays 1 (zero-bubble streaming).
- Backpressure: while out_valid = 1 and out_ready = 0, out_data, out_idx and out_last stay stable. A held in_valid is not accepted.
- in_data and in_bitrev are ignored when no accept occurs. Changing in_bitrev never affects a word already buffered.
- Degenerate case LANES = NUM_COEF: BEATS = 1, out_last = 1 whenever out_valid = 1, out_idx = 0.
- rst mid-word: the buffered word is discarded with no further beats, and all outputs return to reset values on the next edge.

Test Plan:
1. Natural order, defaults: in_data = 64'h0706050403020100, in_bitrev = 0, out_ready = 1 -> four beats on consecutive cycles starting 1 cycle after accept:
   - out_data = 16'h0100, 16'h0302, 16'h0504, 16'h0706
   - out_idx = 0, 2, 4, 6
   - out_last high on beat 3 only
2. Bit-reversed order, same word, in_bitrev = 1 -> out_data = 16'h0400, 16'h0602, 16'h0501, 16'h0703 (order 0,4,2,6,1,5,3,7).
3. Back-to-back: two words, in_valid held, out_ready = 1 -> second word accepted on the cycle of the first word's last beat. 8 beats appear in 8 consecutive cycles with out_valid continuously high.
4. Backpressure: out_ready low for 3 cycles at beat 1 -> out_data held at 16'h0302 and out_idx at 2. A pending in_valid is not accepted until the last beat transfers.
5. Reset mid-stream: rst asserted after beat 1 -> next cycle out_valid = 0, out_data = 0. A fresh word afterwards restarts at beat 0.
6. LANES = 8 instance: single beat out_data = 64'h0706050403020100 with out_last = 1. Bit-reversed single beat = 64'h0703050106020400.
